// File: rtl/fm_ch_seq.sv
// fm_ch_seq: read-side sequencer for the FM channel attribute store.
// On each sample tick it scans channels 0..NUM_CH-1 through the store's
// asynchronous read port, captures pan/feedback, forms the phase increment
// (fnum << block) and presents one record per channel on a valid/ready port.
// Optional build macro FM_CH_SEQ_ZERO_SKIP_EN: channels whose F-number is
// zero are skipped without emitting a record.
module fm_ch_seq #(
  parameter int NUM_CH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  output logic [4:0]  ch_sel,
  input  logic [6:0]  ch_pan,
  input  logic [2:0]  ch_fb,
  input  logic [2:0]  ch_block,
  input  logic [9:0]  ch_fnum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_ch,
  output logic [6:0]  out_pan,
  output logic [2:0]  out_fb,
  output logic [16:0] out_phase_inc,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt,
  input  logic        overrun_clr
);

  localparam logic [4:0] LAST_CH = 5'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  ch_sel_next;
  logic        out_valid_next;
  logic [4:0]  out_ch_next;
  logic [6:0]  out_pan_next;
  logic [2:0]  out_fb_next;
  logic [16:0] out_phase_inc_next;
  logic        busy_next;
  logic        frame_done_next;
  logic [7:0]  overrun_cnt_next;

  logic        last_ch;
  logic        accept;
  logic        skip_ch;
  logic        tick_drop;
  logic [16:0] phase_calc;

  assign last_ch    = (ch_sel == LAST_CH);
  assign accept     = (state_reg == PRESENT) && out_valid && out_ready;
  assign tick_drop  = sample_tick && (state_reg != IDLE);
  // Zero-extend before shifting so block 7 never truncates (max 130944).
  assign phase_calc = {7'b0, ch_fnum} << ch_block;

`ifdef FM_CH_SEQ_ZERO_SKIP_EN
  assign skip_ch = (ch_fnum == 10'd0);
`else
  assign skip_ch = 1'b0;
`endif

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ch_sel        <= 5'd0;
      out_valid     <= 1'b0;
      out_ch        <= 5'd0;
      out_pan       <= 7'd0;
      out_fb        <= 3'd0;
      out_phase_inc <= 17'd0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun_cnt   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      ch_sel        <= ch_sel_next;
      out_valid     <= out_valid_next;
      out_ch        <= out_ch_next;
      out_pan       <= out_pan_next;
      out_fb        <= out_fb_next;
      out_phase_inc <= out_phase_inc_next;
      busy          <= busy_next;
      frame_done    <= frame_done_next;
      overrun_cnt   <= overrun_cnt_next;
    end
  end

  // Next-state selection for the scan sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_tick) state_next = SETTLE;
      SETTLE:  state_next = CAPTURE;
      CAPTURE: begin
        if (skip_ch) state_next = last_ch ? IDLE : SETTLE;
        else         state_next = PRESENT;
      end
      PRESENT: if (accept) state_next = last_ch ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, including the overrun counter.
  always_comb begin
    ch_sel_next        = ch_sel;
    out_valid_next     = out_valid;
    out_ch_next        = out_ch;
    out_pan_next       = out_pan;
    out_fb_next        = out_fb;
    out_phase_inc_next = out_phase_inc;
    busy_next          = busy;
    frame_done_next    = 1'b0;
    overrun_cnt_next   = overrun_cnt;

    case (state_reg)
      IDLE: begin
        if (sample_tick) begin
          ch_sel_next = 5'd0;
          busy_next   = 1'b1;
        end
      end
      SETTLE: begin
        // Address held stable so the asynchronous read data settles.
      end
      CAPTURE: begin
        if (skip_ch) begin
          if (last_ch) begin
            busy_next       = 1'b0;
            frame_done_next = 1'b1;
          end else begin
            ch_sel_next = ch_sel + 5'd1;
          end
        end else begin
          out_ch_next        = ch_sel;
          out_pan_next       = ch_pan;
          out_fb_next        = ch_fb;
          out_phase_inc_next = phase_calc;
          out_valid_next     = 1'b1;
        end
      end
      PRESENT: begin
        if (accept) begin
          out_valid_next = 1'b0;
          if (last_ch) begin
            busy_next       = 1'b0;
            frame_done_next = 1'b1;
          end else begin
            ch_sel_next = ch_sel + 5'd1;
          end
        end
      end
      default: begin
      end
    endcase

    // Clear takes priority over a dropped tick in the same cycle.
    if (overrun_clr)
      overrun_cnt_next = 8'd0;
    else if (tick_drop && (overrun_cnt != 8'hFF))
      overrun_cnt_next = overrun_cnt + 8'd1;
  end

endmodule

// File: tb/tb_fm_ch_seq.sv
// tb_fm_ch_seq: randomized bench for fm_ch_seq with a queue-based record
// model built directly from the attribute store contents.
module tb_fm_ch_seq;

  localparam int NUM_CH = 32;

`ifdef FM_CH_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, sample_tick, out_ready, overrun_clr;
  logic [4:0]  ch_sel, out_ch;
  logic [6:0]  ch_pan, out_pan;
  logic [2:0]  ch_fb, ch_block, out_fb;
  logic [9:0]  ch_fnum;
  logic        out_valid, busy, frame_done;
  logic [16:0] out_phase_inc;
  logic [7:0]  overrun_cnt;

  // Attribute store model with an asynchronous read port.
  logic [6:0] st_pan   [NUM_CH];
  logic [2:0] st_fb    [NUM_CH];
  logic [2:0] st_block [NUM_CH];
  logic [9:0] st_fnum  [NUM_CH];

  assign ch_pan   = st_pan[ch_sel];
  assign ch_fb    = st_fb[ch_sel];
  assign ch_block = st_block[ch_sel];
  assign ch_fnum  = st_fnum[ch_sel];

  fm_ch_seq #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .ch_sel(ch_sel),
    .ch_pan(ch_pan), .ch_fb(ch_fb), .ch_block(ch_block), .ch_fnum(ch_fnum),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_pan(out_pan), .out_fb(out_fb), .out_phase_inc(out_phase_inc),
    .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int pan;
    int fb;
    int phase;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_over = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void bump_over();
    exp_over = (exp_over < 255) ? exp_over + 1 : 255;
  endfunction

  // Expected record list for one frame: channels in order, phase = fnum*2^block.
  function automatic void build_exp();
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      rec_t r;
      if (SKIP && st_fnum[c] == 10'd0) continue;
      r.ch    = c;
      r.pan   = int'(st_pan[c]);
      r.fb    = int'(st_fb[c]);
      r.phase = int'(st_fnum[c]) * (1 << int'(st_block[c]));
      exp_q.push_back(r);
    end
  endfunction

  function automatic void fill_store(input int zero_pct);
    for (int c = 0; c < NUM_CH; c++) begin
      st_pan[c]   = 7'($urandom_range(127));
      st_fb[c]    = 3'($urandom_range(7));
      st_block[c] = 3'($urandom_range(7));
      st_fnum[c]  = ($urandom_range(99) < zero_pct) ? 10'd0 : 10'($urandom_range(1023, 1));
    end
  endfunction

  // Runs one frame from IDLE; returns edges from the tick edge to frame_done
  // and to the first out_valid.
  task automatic run_frame(input int ready_pct, input int stall_ch, input int n_inj,
                           input bit tick_on_last, output int edges, output int first_v);
    int n, stall, inj_left;
    bit done, prev_hold;
    logic [4:0]  s_ch, s_sel;
    logic [6:0]  s_pan;
    logic [2:0]  s_fb;
    logic [16:0] s_ph;
    rec_t r;
    build_exp();
    n = 0; stall = 0; inj_left = n_inj; done = 1'b0; prev_hold = 1'b0;
    edges = -1; first_v = -1;
    s_ch = '0; s_sel = '0; s_pan = '0; s_fb = '0; s_ph = '0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      sample_tick = 1'b0;
      if (frame_done) begin
        check_eq("frame_done_records_left", exp_q.size(), 0);
        done  = 1'b1;
        edges = n;
      end else begin
        if (prev_hold) begin
          check_eq("hold_valid", out_valid, 1'b1);
          check_eq("hold_ch", out_ch, s_ch);
          check_eq("hold_pan", out_pan, s_pan);
          check_eq("hold_fb", out_fb, s_fb);
          check_eq("hold_phase", out_phase_inc, s_ph);
          check_eq("hold_ch_sel", ch_sel, s_sel);
        end
        if (out_valid && first_v < 0) first_v = n;
        if (out_valid && int'(out_ch) == stall_ch && stall < 20) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_record_ch", out_ch, 32);
          end else begin
            r = exp_q.pop_front();
            $display("rec ch=%0d pan=0x%0h fb=%0d phase=0x%0h", out_ch, out_pan, out_fb, out_phase_inc);
            check_eq("rec_ch", out_ch, r.ch);
            check_eq("rec_pan", out_pan, r.pan);
            check_eq("rec_fb", out_fb, r.fb);
            check_eq("rec_phase", out_phase_inc, r.phase);
            if (tick_on_last && exp_q.size() == 0) begin
              sample_tick = 1'b1;
              bump_over();
            end
          end
        end else if (inj_left > 0 && n > 4 && $urandom_range(3) == 0) begin
          sample_tick = 1'b1;
          inj_left--;
          bump_over();
        end
        prev_hold = out_valid && !out_ready;
        s_ch = out_ch; s_pan = out_pan; s_fb = out_fb; s_ph = out_phase_inc; s_sel = ch_sel;
      end
    end
    check_eq("frame_done_seen", done, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("frame_done_pulse_width", frame_done, 1'b0);
    check_eq("idle_after_frame_busy", busy, 1'b0);
    check_eq("overrun_after_frame", overrun_cnt, exp_over);
  endtask

  initial begin
    int edges, first_v, n;
    bit seen;
    reset = 1'b1; sample_tick = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_pan[c] = '0; st_fb[c] = '0; st_block[c] = '0; st_fnum[c] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_ch_sel", ch_sel, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_ch", out_ch, 0);
    check_eq("rst_out_pan", out_pan, 0);
    check_eq("rst_out_fb", out_fb, 0);
    check_eq("rst_out_phase", out_phase_inc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_overrun", overrun_cnt, 0);

    // Directed channels plus full-throughput timing; tick on final handshake.
    fill_store(0);
    st_pan[3] = 7'h40; st_fb[3] = 3'd5; st_block[3] = 3'd4; st_fnum[3] = 10'h155;
    st_block[31] = 3'd7; st_fnum[31] = 10'h3FF;
    st_block[0] = 3'd0; st_fnum[0] = 10'd1;
    run_frame(100, -1, 0, 1'b1, edges, first_v);
    check_eq("frame_edges_full_rate", edges, 96);
    check_eq("first_valid_latency", first_v, 2);

    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0; exp_over = 0;
    check_eq("overrun_clr", overrun_cnt, 0);

    // Random frames with backpressure, a long stall on ch5 and dropped ticks.
    for (int f = 0; f < 4; f++) begin
      fill_store(25);
      if (st_fnum[5] == 10'd0) st_fnum[5] = 10'd77;
      run_frame(60, (f == 0) ? 5 : -1, 3, 1'b0, edges, first_v);
    end

    // Saturation: stall a frame and drop 300 ticks.
    reset = 1'b1; @(negedge clk); reset = 1'b0; exp_over = 0;
    fill_store(0);
    out_ready = 1'b0;
    sample_tick = 1'b1; @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bump_over();
    end
    sample_tick = 1'b0;
    @(negedge clk);
    check_eq("overrun_saturate", overrun_cnt, exp_over);
    sample_tick = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; overrun_clr = 1'b0; exp_over = 0;
    check_eq("overrun_clr_wins", overrun_cnt, exp_over);

    // Reset in the middle of a frame at ch10.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    out_ready = 1'b1;
    sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 500) begin
      @(negedge clk); n++;
      if (out_valid && out_ch == 5'd10) seen = 1'b1;
    end
    check_eq("reach_ch10", seen, 1'b1);
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ch_sel", ch_sel, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (frame_done) seen = 1'b1;
      @(negedge clk);
    end
    check_eq("abort_no_frame_done", seen, 1'b0);
    run_frame(100, -1, 0, 1'b0, edges, first_v);

    // Only ch7 carries a nonzero F-number, then an all-zero frame.
    for (int c = 0; c < NUM_CH; c++) st_fnum[c] = 10'd0;
    st_fnum[7] = 10'h2A5; st_block[7] = 3'd3;
    run_frame(100, -1, 0, 1'b0, edges, first_v);
    st_fnum[7] = 10'd0;
    run_frame(80, -1, 0, 1'b0, edges, first_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
